// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, RV32I load/store funct3 codes, defaults and access-legality helpers
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 2;
  // Legal funct3 for the operation; without sub-word support only word accesses exist
  function automatic logic f3_ok(logic wr, logic [2:0] f3, logic sub);
    return sub ? (wr ? (f3 == SB || f3 == SH || f3 == SW)
                     : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU))
               : f3 == LW;
  endfunction
  // Halfwords need even addresses, words need 4-byte alignment
  function automatic logic misaligned(logic [2:0] f3, logic [1:0] lo);
    return (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port word RAM with per-byte write enables, contents never reset
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);
  logic [31:0] mem_q [DEPTH];
  // Byte-lane writes and registered read of the addressed word
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++)
      if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle data memory controller (IDLE/WAIT/DONE); DMEM_SUBWORD_EN adds byte/halfword access
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  input  logic [2:0]  FUNCT3,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        VALID,
  output logic        ERR
);
  localparam int AW = $clog2(DEPTH);
  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          wr_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic [31:0]   rdata_q;
  logic          valid_q;
  logic          err_q;
  logic          bad;
  logic [31:0]   rdata_d;
  logic [3:0]    be_d;
  logic [31:0]   wd_d;
  logic [31:0]   arr_rdata;
  logic [AW-1:0] arr_addr;
  logic          unused_ok;
  assign unused_ok = ^ADDR[31:AW+2];
`ifdef DMEM_SUBWORD_EN
  localparam logic SUB = 1'b1;
  logic [15:0] sh;
  assign sh = 16'(arr_rdata >> {addr_q[1:0], 3'b000});
  // Load extension and store lane steering for sub-word accesses
  always_comb begin
    rdata_d = f3_q == LB  ? {{24{sh[7]}}, sh[7:0]} :
              f3_q == LH  ? {{16{sh[15]}}, sh} :
              f3_q == LBU ? {24'b0, sh[7:0]} :
              f3_q == LHU ? {16'b0, sh} : arr_rdata;
    be_d    = f3_q == SB ? 4'b0001 << addr_q[1:0] :
              f3_q == SH ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_d    = f3_q == SB ? {4{wdata_q[7:0]}} :
              f3_q == SH ? {2{wdata_q[15:0]}} : wdata_q;
  end
`else
  localparam logic SUB = 1'b0;
  assign rdata_d = arr_rdata;
  assign be_d    = 4'b1111;
  assign wd_d    = wdata_q;
`endif
  assign bad      = !f3_ok(wr_q, f3_q, SUB) || misaligned(f3_q, addr_q[1:0]);
  assign arr_addr = state_q == IDLE ? ADDR[AW+1:2] : addr_q[AW+1:2];
  assign BUSY     = (state_q == IDLE && !(MemRead && MemWrite)) || state_q == WAIT;
  assign RDATA    = rdata_q;
  assign VALID    = valid_q;
  assign ERR      = err_q;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk_i   (CLK),
    .addr_i  (arr_addr),
    .be_i    ({4{state_q == DONE && wr_q && !err_q}} & be_d),
    .wdata_i (wd_d),
    .rdata_o (arr_rdata)
  );
  // Request sequencing with registered completion and load-result outputs
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE:
          if (!MemRead && !MemWrite) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= 1'b1;
          end else if (!MemRead || !MemWrite) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            wr_q    <= !MemWrite;
            addr_q  <= ADDR[AW+1:0];
            wdata_q <= WDATA;
            f3_q    <= FUNCT3;
          end
        WAIT:
          if (cnt_q == 3'(LATENCY - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            err_q   <= bad;
            if (!wr_q && !bad) rdata_q <= rdata_d;
          end else cnt_q <= cnt_q + 3'd1;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench with a transaction-level memory model
module tb_data_mem_ctrl;
  localparam int DEPTH = 256;
  localparam int LATENCY = 2;
`ifdef DMEM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 1'b1;
  logic mem_write = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0] funct3 = 3'b010;
  logic [31:0] rdata;
  logic busy, valid, err;
  int n_tests = 0;
  int n_fail = 0;

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK(clk), .RST_N(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
    .ADDR(addr), .WDATA(wdata), .FUNCT3(funct3),
    .RDATA(rdata), .BUSY(busy), .VALID(valid), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word array plus a timeline of the pending access
  logic [31:0] mem [DEPTH];
  int          m_wait = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [31:0] m_rdata = '0;
  bit          p_wr = 0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_wdata = '0;
  logic [2:0]  p_f3 = '0;

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit illegal(bit wr, logic [2:0] f3, logic [31:0] a);
    int size;
    if (SUB)
      size = (f3 == 3'd2) ? 4 :
             (f3 == 3'd0 || f3 == 3'd1 || (!wr && (f3 == 3'd4 || f3 == 3'd5))) ? (f3[0] ? 2 : 1) : 0;
    else
      size = (f3 == 3'd2) ? 4 : 0;
    return size == 0 || (a % size) != 0;
  endfunction

  function automatic logic [31:0] load(logic [31:0] w, logic [2:0] f3, logic [1:0] lo);
    logic [31:0] v, b, h;
    v = w >> (8 * lo);
    b = v & 32'd255;
    h = v & 32'd65535;
    case (f3)
      3'd0: return b >= 128 ? b - 32'd256 : b;
      3'd1: return h >= 32768 ? h - 32'd65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [2:0] f3, logic [1:0] lo);
    int s;
    s = 8 * lo;
    case (f3)
      3'd0: return (old & ~(32'hFF << s)) | ((wd & 32'hFF) << s);
      3'd1: return (old & ~(32'hFFFF << s)) | ((wd & 32'hFFFF) << s);
      default: return wd;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait = 0; m_done = 0; m_err = 0; m_rdata = '0;
    end else if (m_done) begin
      if (p_wr && !m_err) mem[widx(p_addr)] = merge(mem[widx(p_addr)], p_wdata, p_f3, p_addr[1:0]);
      m_done = 0; m_err = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_done = 1;
        m_err = illegal(p_wr, p_f3, p_addr);
        if (!p_wr && !m_err) m_rdata = load(mem[widx(p_addr)], p_f3, p_addr[1:0]);
      end
    end else if (!mem_read && !mem_write) begin
      m_done = 1; m_err = 1; p_wr = 0;
    end else if (!mem_read || !mem_write) begin
      p_wr = !mem_write; p_addr = addr; p_wdata = wdata; p_f3 = funct3;
      m_wait = LATENCY;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("busy", busy, (m_wait > 0) || (!m_done && !(mem_read && mem_write)));
    chk("valid", valid, m_done);
    chk("err", err, m_done && m_err);
    chk("rdata", rdata, m_rdata);
  end

  task automatic op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f3, input bit hold, output int lat, output bit e, output bit b);
    @(negedge clk);
    #2;
    mem_read = !r; mem_write = !w; addr = a; wdata = d; funct3 = f3;
    @(negedge clk);
    lat = 1;
    if (!hold) begin
      #2;
      mem_read = 1'b1; mem_write = 1'b1; addr = $urandom; wdata = $urandom;
    end
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = err;
    b = busy;
    if (!valid) chk("completion_timeout", valid, 1'b1);
    #2;
    mem_read = 1'b1; mem_write = 1'b1;
  endtask

  logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    int lat;
    bit e, b;
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) op(0, 1, i * 4, $urandom, 3'd2, 0, lat, e, b);
    op(0, 1, 32'h10, 32'hDEADBEEF, 3'd2, 0, lat, e, b);
    op(1, 0, 32'h10, 32'h0, 3'd2, 0, lat, e, b);
    chk("lw_latency", lat, LATENCY + 1);
    chk("lw_data", rdata, 32'hDEADBEEF);
    op(1, 0, 32'h22, 32'h0, 3'd2, 0, lat, e, b);
    chk("misaligned_err", e, 1'b1);
    chk("misaligned_rdata_held", rdata, 32'hDEADBEEF);
    op(1, 1, 32'h10, 32'h55, 3'd2, 1, lat, e, b);
    chk("both_low_err", e, 1'b1);
    chk("both_low_busy", b, 1'b0);
    chk("both_low_latency", lat, 1);
    op(0, 1, 32'h12, 32'h11111111, 3'd2, 0, lat, e, b);
    op(1, 0, 32'h10, 32'h0, 3'd2, 0, lat, e, b);
    chk("no_change_after_errors", rdata, 32'hDEADBEEF);
    op(0, 1, 32'h400, 32'h0BADF00D, 3'd2, 0, lat, e, b);
    op(1, 0, 32'h0, 32'h0, 3'd2, 0, lat, e, b);
    chk("wrap_around", rdata, 32'h0BADF00D);
    op(0, 1, 32'h0, 32'hCAFEF00D, 3'd2, 0, lat, e, b);
    @(negedge clk);
    #2;
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0; wdata = 32'h1234; funct3 = 3'd2;
    @(posedge clk);
    #2;
    mem_read = 1'b1; mem_write = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_wait_busy", busy, 1'b0);
    chk("rst_wait_rdata", rdata, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op(1, 0, 32'h0, 32'h0, 3'd2, 0, lat, e, b);
    chk("rst_aborts_write", rdata, 32'hCAFEF00D);
`ifdef DMEM_SUBWORD_EN
    op(0, 1, 32'h20, 32'h000080FF, 3'd2, 0, lat, e, b);
    op(1, 0, 32'h20, 32'h0, 3'd0, 0, lat, e, b);
    chk("lb_sign", rdata, 32'hFFFFFFFF);
    op(1, 0, 32'h20, 32'h0, 3'd4, 0, lat, e, b);
    chk("lbu_zero", rdata, 32'h000000FF);
    op(1, 0, 32'h20, 32'h0, 3'd1, 0, lat, e, b);
    chk("lh_sign", rdata, 32'hFFFF80FF);
    op(0, 1, 32'h21, 32'h777777AB, 3'd0, 0, lat, e, b);
    op(1, 0, 32'h20, 32'h0, 3'd2, 0, lat, e, b);
    chk("sb_lane", rdata, 32'h0000ABFF);
`endif
    repeat (400) begin
      int k;
      bit r, w;
      logic [31:0] a;
      logic [2:0] f3;
      k = $urandom_range(0, 19);
      r = (k < 9) || (k >= 18);
      w = (k >= 9);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : (SUB ? f3s[$urandom_range(0, 4)] : 3'd2);
      op(r, w, a, $urandom, f3, bit'($urandom_range(0, 1)), lat, e, b);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
